// File: rtl/wca_pkg.sv
// wca_pkg: shared types, defaults and helpers for width_change_arb and its round-robin picker.
package wca_pkg;

    localparam int DEF_BYTES_PER_GROUP  = 3;
    localparam int DEF_GROUPS_PER_GRANT = 2;

    typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, PAD = 2'd2} state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Scans downward so the smallest offset after 'last' wins; offset n is 'last' itself,
    // which lets a lone active requester be regranted.
    function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] last, input int n);
        logic [2:0] pick;
        int idx;
        pick = last;
        for (int i = n; i >= 1; i--) begin
            idx = (int'(last) + i) % n;
            if (req[3'(idx)]) pick = 3'(idx);
        end
        return pick;
    endfunction

endpackage

// File: rtl/width_change_arb_if.sv
// width_change_arb_if: requester-side handshake and converter-side byte stream of width_change_arb.
interface width_change_arb_if
    import wca_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int AWIDTH = 8,
    parameter int IW     = clog2(NREQ)
);
    logic [NREQ-1:0]        s_vld;
    logic [NREQ*AWIDTH-1:0] s_data;
    logic [NREQ-1:0]        s_rdy;
    logic                   m_vld;
    logic [AWIDTH-1:0]      m_data;
    logic [IW-1:0]          grant_id;
    logic                   busy;
    logic [7:0]             pad_cnt;

    modport master (output s_vld, s_data, input s_rdy, m_vld, m_data, grant_id, busy, pad_cnt);
    modport slave  (input s_vld, s_data, output s_rdy, m_vld, m_data, grant_id, busy, pad_cnt);
endinterface

// File: rtl/wca_rr_picker.sv
// wca_rr_picker: combinational round-robin search for the first request after 'last', with wrap.
module wca_rr_picker
    import wca_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] pick
);
    always_comb pick = IW'(rr_pick(8'(req), 3'(last), N));
endmodule

// File: rtl/width_change_arb.sv
// width_change_arb: round-robin arbiter feeding a shared 8->12 converter in whole alignment groups.
// Define WCA_PAD_EN to zero-pad a group whose requester stalls for TIMEOUT cycles.
module width_change_arb
    import wca_pkg::*;
#(
    parameter int NREQ             = 4,
    parameter int AWIDTH           = 8,
    parameter int BYTES_PER_GROUP  = DEF_BYTES_PER_GROUP,
    parameter int GROUPS_PER_GRANT = DEF_GROUPS_PER_GRANT,
    parameter int TIMEOUT          = 16
) (
    input logic clk,
    input logic rst_n,
    width_change_arb_if.slave bus
);
    localparam int IW = clog2(NREQ);
    localparam int BW = clog2(BYTES_PER_GROUP + 1);
    localparam int GW = clog2(GROUPS_PER_GRANT + 1);
    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_GRANT = GRANT;
    localparam logic [1:0] S_PAD   = PAD;

    if (NREQ < 2 || NREQ > 8 || BYTES_PER_GROUP < 2 || GROUPS_PER_GRANT < 1 || TIMEOUT < 1) begin : g_bad_param
        $error("width_change_arb: parameter out of range");
    end

    logic [1:0]        state;
    logic [IW-1:0]     grant_id;
    logic [IW-1:0]     pick;
    logic [BW-1:0]     byte_cnt;
    logic [GW-1:0]     grp_cnt;
    logic              m_vld;
    logic [AWIDTH-1:0] m_data;
    logic [AWIDTH-1:0] cur;
    logic              xfer;
    logic              grp_end;
    logic              last_grp;
    logic              pad;
    logic              timeout;

    wca_rr_picker #(.N(NREQ)) u_pick (.req(bus.s_vld), .last(grant_id), .pick(pick));

    assign xfer     = state == S_GRANT && bus.s_vld[grant_id];
    assign cur      = bus.s_data[int'(grant_id)*AWIDTH +: AWIDTH];
    assign grp_end  = byte_cnt == BW'(BYTES_PER_GROUP - 1);
    assign last_grp = grp_cnt == GW'(GROUPS_PER_GRANT - 1);
    assign pad      = state == S_PAD;

    assign bus.s_rdy    = (state == S_GRANT) ? (NREQ'(1) << grant_id) : '0;
    assign bus.m_vld    = m_vld;
    assign bus.m_data   = m_data;
    assign bus.grant_id = grant_id;
    assign bus.busy     = state == S_GRANT;

`ifdef WCA_PAD_EN
    localparam int SW = clog2(TIMEOUT + 1);
    logic [SW-1:0] stall_cnt;
    logic [7:0]    pad_cnt;
    logic          stall;

    assign stall       = state == S_GRANT && !xfer && byte_cnt != '0;
    assign timeout     = stall && stall_cnt == SW'(TIMEOUT - 1);
    assign bus.pad_cnt = pad_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            pad_cnt   <= '0;
        end else begin
            stall_cnt <= (stall && !timeout) ? stall_cnt + 1'b1 : '0;
            if (pad && grp_end && pad_cnt != 8'hff) pad_cnt <= pad_cnt + 8'd1;
        end
    end
`else
    assign timeout     = 1'b0;
    assign bus.pad_cnt = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            grant_id <= IW'(NREQ - 1);
            byte_cnt <= '0;
            grp_cnt  <= '0;
            m_vld    <= 1'b0;
            m_data   <= '0;
        end else begin
            m_vld <= xfer || pad;
            if (xfer || pad) m_data <= pad ? '0 : cur;
            case (state)
                S_IDLE:
                    if (|bus.s_vld) begin
                        grant_id <= pick;
                        state    <= S_GRANT;
                    end
                S_GRANT:
                    if (xfer) begin
                        byte_cnt <= grp_end ? '0 : byte_cnt + 1'b1;
                        if (grp_end) begin
                            grp_cnt <= last_grp ? '0 : grp_cnt + 1'b1;
                            if (last_grp) state <= S_IDLE;
                        end
                    end else if (byte_cnt == '0) begin
                        grp_cnt <= '0;
                        state   <= S_IDLE;
                    end else if (timeout) begin
                        state <= S_PAD;
                    end
                // Pad bytes finish the open group; the grant is released regardless of groups left.
                S_PAD: begin
                    byte_cnt <= grp_end ? '0 : byte_cnt + 1'b1;
                    if (grp_end) begin
                        grp_cnt <= '0;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_width_change_arb.sv
// tb_width_change_arb: directed stimulus with a byte/word scoreboard checked by an independent monitor.
module tb_width_change_arb;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    width_change_arb_if #(.NREQ(4), .AWIDTH(8)) bus ();

    width_change_arb #(
        .NREQ(4), .AWIDTH(8), .BYTES_PER_GROUP(3), .GROUPS_PER_GRANT(2), .TIMEOUT(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    typedef struct packed {logic [1:0] src; logic [7:0] d;} exp_t;
    exp_t        exp_q[$];
    logic [11:0] exp_w[$];
    int          gap_q[$];
    logic [7:0]  txq[4][$];
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic extra(input string name, input logic [31:0] act);
        total++;
        bad++;
        $display("FAIL %s: got %0h with nothing expected", name, act);
    endtask

    function automatic void expb(input int r, input logic [7:0] d);
        txq[r].push_back(d);
        exp_q.push_back('{src: 2'(r), d: d});
    endfunction

    // Converter model: bytes b0,b1,b2 pack as {b0,b1[7:4]} then {b1[3:0],b2}.
    initial begin
        int ph = 0;
        int gap = 0;
        bit have = 0;
        logic [1:0] prev = '0;
        logic [7:0] hold = '0;
        logic [11:0] w;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ph = 0; gap = 0; have = 0;
            end else if (!bus.m_vld) begin
                gap++;
            end else begin
                if (exp_q.size() == 0) extra("byte", 32'(bus.m_data));
                else begin
                    e = exp_q.pop_front();
                    chk("m_data", 32'(bus.m_data), 32'(e.d));
                    chk("src", 32'(bus.grant_id), 32'(e.src));
                    if (have && e.src != prev) gap_q.push_back(gap);
                    prev = e.src; have = 1;
                end
                gap = 0;
                if (ph != 0) begin
                    w = (ph == 1) ? {hold, bus.m_data[7:4]} : {hold[3:0], bus.m_data};
                    if (exp_w.size() == 0) extra("word", 32'(w));
                    else chk("word", 32'(w), 32'(exp_w.pop_front()));
                end
                hold = bus.m_data;
                ph = (ph + 1) % 3;
            end
        end
    end

    task automatic drive(input int r, input int gap_at, input int gap_len);
        int sent = 0;
        int guard = 0;
        while (txq[r].size() > 0 && guard < 500) begin
            if (sent == gap_at) begin
                bus.s_vld[r] = 1'b0;
                repeat (gap_len) begin
                    @(posedge clk); #1;
                    chk("gap_m_vld", 32'(bus.m_vld), 0);
                    chk("gap_grant", 32'(bus.grant_id), 32'(r));
                end
            end
            bus.s_vld[r] = 1'b1;
            bus.s_data[r*8 +: 8] = txq[r][0];
            @(negedge clk);
            guard++;
            if (bus.s_rdy[r]) begin
                @(posedge clk); #1;
                void'(txq[r].pop_front());
                sent++;
            end
        end
        if (guard >= 500) extra("drive_timeout", 32'(r));
        bus.s_vld[r] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || exp_w.size() != 0) && n < 300) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("drain_bytes", 32'(exp_q.size()), 0);
        chk("drain_words", 32'(exp_w.size()), 0);
    endtask

    task automatic check_reset_values();
        chk("rst_m_vld", 32'(bus.m_vld), 0);
        chk("rst_m_data", 32'(bus.m_data), 0);
        chk("rst_s_rdy", 32'(bus.s_rdy), 0);
        chk("rst_grant_id", 32'(bus.grant_id), 3);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_pad_cnt", 32'(bus.pad_cnt), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.s_vld = '0;
        bus.s_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values();
        gap_q.delete();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.s_vld = '0;
        bus.s_data = '0;

        // single requester, two full groups
        do_reset();
        expb(0, 8'h55); expb(0, 8'haa); expb(0, 8'hbb); expb(0, 8'hcc); expb(0, 8'hdd); expb(0, 8'hee);
        exp_w.push_back(12'h55a); exp_w.push_back(12'habb); exp_w.push_back(12'hccd); exp_w.push_back(12'hdee);
        drive(0, -1, 0);
        chk("single_idle", 32'(bus.busy), 0);
        chk("single_grant", 32'(bus.grant_id), 0);
        drain();

        // contention between req0 and req2: 6-byte grants alternate 0,2,0,2
        do_reset();
        for (int i = 1; i <= 6; i++) expb(0, 8'(i));
        for (int i = 1; i <= 6; i++) expb(2, 8'(8'h20 + i));
        for (int i = 7; i <= 12; i++) expb(0, 8'(i));
        for (int i = 7; i <= 12; i++) expb(2, 8'(8'h20 + i));
        exp_w.push_back(12'h010); exp_w.push_back(12'h203); exp_w.push_back(12'h040); exp_w.push_back(12'h506);
        exp_w.push_back(12'h212); exp_w.push_back(12'h223); exp_w.push_back(12'h242); exp_w.push_back(12'h526);
        exp_w.push_back(12'h070); exp_w.push_back(12'h809); exp_w.push_back(12'h0a0); exp_w.push_back(12'hb0c);
        exp_w.push_back(12'h272); exp_w.push_back(12'h829); exp_w.push_back(12'h2a2); exp_w.push_back(12'hb2c);
        fork
            drive(0, -1, 0);
            drive(2, -1, 0);
        join
        drain();
        chk("bubble_count", 32'(gap_q.size()), 3);
        foreach (gap_q[i]) chk("bubble_len", 32'(gap_q[i]), 1);

        // mid-group stall on req1 while req3 waits
        do_reset();
        expb(1, 8'h11); expb(1, 8'h22); expb(1, 8'h33);
        expb(3, 8'h3a); expb(3, 8'h3b); expb(3, 8'h3c);
        exp_w.push_back(12'h112); exp_w.push_back(12'h233); exp_w.push_back(12'h3a3); exp_w.push_back(12'hb3c);
        fork
            drive(1, 2, 5);
            drive(3, -1, 0);
        join
        drain();

        // early release at a group boundary, req1 pending
        do_reset();
        expb(0, 8'h01); expb(0, 8'h02); expb(0, 8'h03);
        expb(1, 8'h10); expb(1, 8'h20); expb(1, 8'h30);
        exp_w.push_back(12'h010); exp_w.push_back(12'h203); exp_w.push_back(12'h102); exp_w.push_back(12'h030);
        fork
            begin
                drive(0, -1, 0);
                @(posedge clk); #1;
                chk("early_idle", 32'(bus.busy), 0);
                @(posedge clk); #1;
                chk("early_busy", 32'(bus.busy), 1);
                chk("early_grant", 32'(bus.grant_id), 1);
            end
            drive(1, -1, 0);
        join
        drain();

        // asynchronous reset after 2 of 3 bytes
        do_reset();
        expb(0, 8'h11); expb(0, 8'h22);
        exp_w.push_back(12'h112);
        drive(0, -1, 0);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_reset_values();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        expb(0, 8'haa); expb(0, 8'hbb); expb(0, 8'hcc);
        exp_w.push_back(12'haab); exp_w.push_back(12'hbcc);
        drive(0, -1, 0);
        drain();

`ifdef WCA_PAD_EN
        // stalled group is zero-padded after TIMEOUT=4 cycles
        do_reset();
        expb(2, 8'h77);
        exp_q.push_back('{src: 2'd2, d: 8'h00});
        exp_q.push_back('{src: 2'd2, d: 8'h00});
        exp_w.push_back(12'h770); exp_w.push_back(12'h000);
        drive(2, -1, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("pad_stall_rdy", 32'(bus.s_rdy), 32'h4);
        @(posedge clk); #1;
        chk("pad_rdy_drop", 32'(bus.s_rdy), 0);
        drain();
        chk("pad_cnt", 32'(bus.pad_cnt), 1);
        chk("pad_released", 32'(bus.busy), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
